// File: rtl/bubble_flash_page_reader.sv
// bubble_flash_page_reader: fetches one bubble page from a W25Q32 over SPI
// mode 0 and streams the bytes into the emulator page buffer.
// Optional feature macro: BUBBLE_FLASH_FASTREAD_EN selects Fast Read (0x0B)
// with 8 dummy clocks; without it, Read Data (0x03) with no dummy phase.
module bubble_flash_page_reader #(
  parameter int SPI_DIV    = 2,
  parameter int PAGE_BYTES = 64,
  parameter int DESEL_CYC  = 4,
  localparam int AW        = $clog2(PAGE_BYTES)
) (
  input  logic          MCLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic [2:0]    IMGNUM,
  input  logic [12:0]   PAGE,
  output logic          BUSY,
  output logic          DONE,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [7:0]    WR_DATA,
  output logic          nROMCS,
  output logic          ROMCLK,
  output logic          ROMMOSI,
  input  logic          ROMMISO
);

`ifdef BUBBLE_FLASH_FASTREAD_EN
  localparam logic [7:0] RD_CMD     = 8'h0B;
  localparam int         DUMMY_BITS = 8;
`else
  localparam logic [7:0] RD_CMD     = 8'h03;
  localparam int         DUMMY_BITS = 0;
`endif

  // Bit positions on the wire: command 0..7, address 8..31, dummy, then data.
  // DATA_START is a multiple of 8, so bit_cnt[2:0] is the bit-in-byte index.
  localparam int DATA_START = 32 + DUMMY_BITS;
  localparam int N_BITS     = DATA_START + 8 * PAGE_BYTES;
  localparam int BW         = $clog2(N_BITS);
  localparam int DW         = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int DCW        = (DESEL_CYC > 1) ? $clog2(DESEL_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DCW-1:0]  desel_cnt;
  logic [30:0]     tx_sr;     // remaining command/address bits after bit 7
  logic [6:0]      rx_sr;     // first seven bits of the byte in flight
  logic [23:0]     flash_addr;
  logic            accept, spi_active, tick, rise, fall;

  assign accept     = (state == S_IDLE) && REQ;
  assign spi_active = (state == S_CMD) || (state == S_ADDR) ||
                      (state == S_DUMMY) || (state == S_DATA);
  assign tick       = (div_cnt == DW'(SPI_DIV - 1));
  assign rise       = spi_active && tick && !ROMCLK;
  assign fall       = spi_active && tick && ROMCLK;
  assign flash_addr = 24'({IMGNUM, PAGE}) << AW;

  // State register
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: phase changes happen on the falling ROMCLK that ends a phase
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (REQ) state_nxt = S_CMD;
      S_CMD:   if (fall && bit_cnt == BW'(7)) state_nxt = S_ADDR;
      S_ADDR:  if (fall && bit_cnt == BW'(31))
                 state_nxt = (DUMMY_BITS > 0) ? S_DUMMY : S_DATA;
      S_DUMMY: if (fall && bit_cnt == BW'(DATA_START - 1)) state_nxt = S_DATA;
      S_DATA:  if (fall && bit_cnt == BW'(N_BITS - 1)) state_nxt = S_DESEL;
      S_DESEL: if (desel_cnt == DCW'(DESEL_CYC - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, SPI clock divider and bit/deselect counters
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= 8'h00;
      nROMCS    <= 1'b1;
      ROMCLK    <= 1'b0;
      ROMMOSI   <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      desel_cnt <= '0;
    end else begin
      BUSY   <= (state_nxt != S_IDLE);
      DONE   <= (state == S_DESEL) && (state_nxt == S_IDLE);
      nROMCS <= !((state_nxt == S_CMD) || (state_nxt == S_ADDR) ||
                  (state_nxt == S_DUMMY) || (state_nxt == S_DATA));
      WR_EN  <= 1'b0;
      if (WR_EN && WR_ADDR != AW'(PAGE_BYTES - 1)) WR_ADDR <= WR_ADDR + AW'(1);
      if (state == S_DESEL) desel_cnt <= desel_cnt + DCW'(1);
      else                  desel_cnt <= '0;
      if (accept) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        ROMCLK  <= 1'b0;
        ROMMOSI <= RD_CMD[7];
        WR_ADDR <= '0;
      end else if (spi_active) begin
        if (tick) begin
          div_cnt <= '0;
          ROMCLK  <= !ROMCLK;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        if (rise && state == S_DATA && bit_cnt[2:0] == 3'd7) begin
          WR_EN   <= 1'b1;
          WR_DATA <= {rx_sr, ROMMISO};
        end
        if (fall) begin
          bit_cnt <= bit_cnt + BW'(1);
          // tx_sr drains to zero after the address, so dummy/data send 0
          ROMMOSI <= tx_sr[30];
        end
      end
    end
  end

  // Serial shift registers (pure datapath, no reset needed)
  always_ff @(posedge MCLK) begin
    if (accept)    tx_sr <= {RD_CMD[6:0], flash_addr};
    else if (fall) tx_sr <= {tx_sr[29:0], 1'b0};
    if (rise)      rx_sr <= {rx_sr[5:0], ROMMISO};
  end

endmodule
